// File: rtl/gmac_tx_frame_fifo.sv
// Store-and-forward byte FIFO feeding one gmac EMAC transmit channel.
// Whole frames are buffered before playout; frames larger than the buffer are discarded.
module gmac_tx_frame_fifo #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic       clk125,
  input  logic       resetn,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_ack,
  output logic       tx_drop
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PTR_W-1:0] FULL_OCC = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT_ACK, RD_SEND, RD_GAP} rd_state_t;

  logic [8:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_commit;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_addr;
  logic [PTR_W-1:0] occupancy;
  logic [PTR_W-1:0] frame_count;
  logic             full;
  logic             init_done;
  logic             drop_st;
  logic             accept;
  logic             wr_en;
  logic             commit;
  logic             drop_start;
  logic             frame_done;
  logic             tx_last;
  rd_state_t        rd_state;

  assign occupancy  = wr_ptr - rd_ptr;
  assign full       = (occupancy == FULL_OCC);
  assign s_tready   = resetn & init_done & (drop_st | ~full);
  assign accept     = s_tvalid & s_tready;
  assign wr_en      = accept & ~drop_st;
  assign commit     = wr_en & s_tlast;
  // A full buffer holding no complete frame can only contain the head of an oversize frame.
  assign drop_start = ~drop_st & full & (frame_count == '0) & s_tvalid;

  // Write side: accept, commit on last byte, or discard an oversize frame
  always_ff @(posedge clk125) begin
    if (!resetn) begin
      init_done <= 1'b0;
      wr_ptr    <= '0;
      wr_commit <= '0;
      drop_st   <= 1'b0;
      tx_drop   <= 1'b0;
    end else begin
      init_done <= 1'b1;
      tx_drop   <= 1'b0;
      if (drop_st) begin
        if (accept && s_tlast) begin
          drop_st <= 1'b0;
          tx_drop <= 1'b1;
        end
      end else if (drop_start) begin
        wr_ptr  <= wr_commit;
        drop_st <= 1'b1;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (s_tlast) wr_commit <= wr_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk125) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_tlast, s_tdata};
  end

  // The presented byte leaves tx_data when acked (byte 0) or every SEND cycle.
  assign frame_done = tx_last & (((rd_state == RD_WAIT_ACK) & tx_ack) | (rd_state == RD_SEND));

  always_ff @(posedge clk125) begin
    if (!resetn) begin
      frame_count <= '0;
    end else if (commit && !frame_done) begin
      frame_count <= frame_count + PTR_ONE;
    end else if (frame_done && !commit) begin
      frame_count <= frame_count - PTR_ONE;
    end
  end

  // rd_ptr addresses the byte on tx_data; the next byte is fetched one ahead so SEND has no bubble.
  assign rd_addr = ((rd_state == RD_IDLE) || (rd_state == RD_GAP)) ? rd_ptr : rd_ptr + PTR_ONE;

  // Read side: present byte 0, wait for ack, stream the rest, then one idle gap cycle
  always_ff @(posedge clk125) begin
    if (!resetn) begin
      rd_state      <= RD_IDLE;
      rd_ptr        <= '0;
      tx_data       <= '0;
      tx_last       <= 1'b0;
      tx_data_valid <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE, RD_GAP: begin
          if (frame_count != '0) begin
            {tx_last, tx_data} <= mem[rd_addr[ADDR_WIDTH-1:0]];
            tx_data_valid      <= 1'b1;
            rd_state           <= RD_WAIT_ACK;
          end else begin
            tx_data_valid <= 1'b0;
            rd_state      <= RD_IDLE;
          end
        end
        RD_WAIT_ACK: begin
          if (tx_ack) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            if (tx_last) begin
              tx_data_valid <= 1'b0;
              rd_state      <= RD_GAP;
            end else begin
              {tx_last, tx_data} <= mem[rd_addr[ADDR_WIDTH-1:0]];
              rd_state           <= RD_SEND;
            end
          end
        end
        RD_SEND: begin
          rd_ptr <= rd_ptr + PTR_ONE;
          if (tx_last) begin
            tx_data_valid <= 1'b0;
            rd_state      <= RD_GAP;
          end else begin
            {tx_last, tx_data} <= mem[rd_addr[ADDR_WIDTH-1:0]];
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmac_tx_frame_fifo.sv
// Directed bench for gmac_tx_frame_fifo: a large (4096 B) and a small (64 B) instance share
// the stimulus, selected by sel; a negedge monitor pops expected bytes and drives tx_ack.
module tb_gmac_tx_frame_fifo;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_SEND = 2;

  logic       clk125 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       tx_ack = 1'b0;
  logic       sel = 1'b0;

  logic       s_tready_l, s_tready_s, tx_data_valid_l, tx_data_valid_s, tx_drop_l, tx_drop_s;
  logic [7:0] tx_data_l, tx_data_s;
  logic       s_tready_m, tx_data_valid_m, tx_drop_m;
  logic [7:0] tx_data_m;

  int n_assert = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];
  int   phase = P_IDLE;
  int   hold_cnt = 0, last_hold = 0, idle_cnt = 0, cur_idx = 0;
  int   ack_delay = 0, frames_done = 0, drop_cnt = 0, gaps_checked = 0;
  bit   ack_hold = 0, gap_mode = 0, prev_end = 0, cur_last = 0, ack_s;
  logic [7:0] cur_byte = '0;
  logic [8:0] e;

  always #4 clk125 = ~clk125;

  gmac_tx_frame_fifo #(.ADDR_WIDTH(12)) dut_l (
    .clk125(clk125), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid & ~sel),
    .s_tready(s_tready_l), .s_tlast(s_tlast), .tx_data(tx_data_l),
    .tx_data_valid(tx_data_valid_l), .tx_ack(tx_ack & ~sel), .tx_drop(tx_drop_l));

  gmac_tx_frame_fifo #(.ADDR_WIDTH(6)) dut_s (
    .clk125(clk125), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid & sel),
    .s_tready(s_tready_s), .s_tlast(s_tlast), .tx_data(tx_data_s),
    .tx_data_valid(tx_data_valid_s), .tx_ack(tx_ack & sel), .tx_drop(tx_drop_s));

  assign s_tready_m      = sel ? s_tready_s : s_tready_l;
  assign tx_data_m       = sel ? tx_data_s : tx_data_l;
  assign tx_data_valid_m = sel ? tx_data_valid_s : tx_data_valid_l;
  assign tx_drop_m       = tx_drop_l | tx_drop_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic end_frame();
    check("gap_valid_low", tx_data_valid_m, 1'b0);
    phase = P_IDLE;
    idle_cnt = 1;
    prev_end = gap_mode;
    frames_done++;
  endtask

  task automatic next_byte();
    check("send_valid", tx_data_valid_m, 1'b1);
    check("send_queue_nonempty", exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("send_data", tx_data_m, e[7:0]);
      cur_last = e[8];
      cur_idx++;
      phase = P_SEND;
    end
  endtask

  // Monitor: tx_ack seen here is the value the DUT sampled at the preceding posedge.
  always @(negedge clk125) begin
    ack_s = tx_ack;
    if (tx_drop_m) drop_cnt++;
    if (!resetn) begin
      exp_q.delete();
      phase = P_IDLE;
      tx_ack = 1'b0;
      prev_end = 0;
      idle_cnt = 0;
    end else begin
      case (phase)
        P_IDLE: begin
          if (tx_data_valid_m) begin
            if (gap_mode && prev_end) begin
              check("gap_len", idle_cnt, 1);
              gaps_checked++;
            end
            prev_end = 0;
            check("frame_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("byte0_data", tx_data_m, e[7:0]);
              cur_byte = e[7:0];
              cur_last = e[8];
              cur_idx = 0;
              hold_cnt = 1;
              phase = P_WAIT;
            end
          end else begin
            idle_cnt++;
          end
        end
        P_WAIT: begin
          if (ack_s) begin
            last_hold = hold_cnt;
            if (cur_last) end_frame();
            else next_byte();
          end else begin
            check("hold_valid", tx_data_valid_m, 1'b1);
            check("hold_data", tx_data_m, cur_byte);
            hold_cnt++;
          end
        end
        default: begin
          if (cur_last) end_frame();
          else next_byte();
        end
      endcase
      tx_ack = (phase == P_WAIT) && !ack_hold && (hold_cnt > ack_delay);
    end
  end

  task automatic put_byte(input logic [7:0] d, input logic last, input bit keep, output bit ok);
    int waited;
    bit rdy;
    s_tdata = d;
    s_tlast = last;
    s_tvalid = 1'b1;
    waited = 0;
    ok = 0;
    while (!ok && waited < 400) begin
      @(negedge clk125);
      rdy = s_tready_m;
      @(posedge clk125);
      if (rdy) ok = 1;
      else waited++;
    end
    if (ok && keep) exp_q.push_back({last, d});
    #1;
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input bit keep);
    bit ok;
    ok = 1;
    for (int i = 0; i < len && ok; i++) put_byte(base + 8'(i), (i == len - 1), keep, ok);
    check("tready_not_stuck", ok, 1'b1);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk125);
      if (exp_q.size() == 0 && phase == P_IDLE && !tx_data_valid_m) done = 1;
    end
    check("drain_complete", done, 1'b1);
    repeat (2) @(posedge clk125);
    #1;
  endtask

  initial begin
    int  f0, d0, k;
    bit  found, any_high;

    // Reset state
    repeat (3) @(posedge clk125);
    @(negedge clk125);
    check("rst_tready_l", s_tready_l, 1'b0);
    check("rst_tready_s", s_tready_s, 1'b0);
    check("rst_valid_l", tx_data_valid_l, 1'b0);
    check("rst_data_l", tx_data_l, 8'h00);
    check("rst_drop_l", tx_drop_l, 1'b0);
    check("rst_valid_s", tx_data_valid_s, 1'b0);
    @(posedge clk125); #1 resetn = 1'b1;
    @(posedge clk125);
    @(negedge clk125);
    check("tready_after_rst_l", s_tready_l, 1'b1);
    check("tready_after_rst_s", s_tready_s, 1'b1);
    @(posedge clk125); #1;

    // Single 64-byte frame, ack three cycles after valid rises
    ack_delay = 3;
    f0 = frames_done;
    send_frame(64, 8'h00, 1);
    wait_idle();
    check("single_hold_cycles", last_hold, 4);
    check("single_frames", frames_done - f0, 1);
    check("single_no_drop", drop_cnt, 0);

    // 1-byte frame
    ack_delay = 2;
    send_frame(1, 8'hA5, 1);
    wait_idle();
    check("one_byte_hold", last_hold, 3);

    // Three back-to-back 60-byte frames with immediate ack
    ack_delay = 0;
    gap_mode = 1;
    f0 = frames_done;
    send_frame(60, 8'h10, 1);
    send_frame(60, 8'h50, 1);
    send_frame(60, 8'h90, 1);
    wait_idle();
    gap_mode = 0;
    check("b2b_frames", frames_done - f0, 3);
    check("b2b_gaps_checked", gaps_checked, 2);
    check("b2b_frame_count", dut_l.frame_count, 0);

    // Oversize drop on the 64-byte instance
    sel = 1'b1;
    d0 = drop_cnt;
    f0 = frames_done;
    send_frame(100, 8'h80, 0);
    send_frame(10, 8'hE0, 1);
    wait_idle();
    check("drop_pulse_cycles", drop_cnt - d0, 1);
    check("drop_frames_sent", frames_done - f0, 1);

    // Backpressure: two 32-byte frames fill the buffer while ack is held off
    ack_hold = 1;
    d0 = drop_cnt;
    f0 = frames_done;
    send_frame(32, 8'h00, 1);
    send_frame(32, 8'h40, 1);
    @(negedge clk125);
    check("full_tready_low", s_tready_s, 1'b0);
    repeat (3) @(negedge clk125);
    check("full_tready_still_low", s_tready_s, 1'b0);
    @(posedge clk125); #1 ack_hold = 0;
    found = 0;
    k = 0;
    while (!found && k < 3) begin
      @(negedge clk125);
      if (s_tready_s) found = 1;
      k++;
    end
    check("tready_recovers", found, 1'b1);
    @(posedge clk125); #1;
    wait_idle();
    check("bp_frames", frames_done - f0, 2);
    check("bp_no_drop", drop_cnt - d0, 0);

    // Reset during transmit of a 64-byte frame
    sel = 1'b0;
    send_frame(64, 8'h40, 1);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk125);
      if (phase == P_SEND && cur_idx >= 19) found = 1;
    end
    check("reached_byte20", found, 1'b1);
    #1 resetn = 1'b0;
    @(posedge clk125); #1 resetn = 1'b1;
    @(negedge clk125);
    check("valid_after_reset", tx_data_valid_l, 1'b0);
    check("fc_after_reset", dut_l.frame_count, 0);
    any_high = 0;
    repeat (20) begin
      @(negedge clk125);
      any_high |= tx_data_valid_l;
    end
    check("valid_stays_low", any_high, 1'b0);
    @(posedge clk125); #1;
    f0 = frames_done;
    ack_delay = 1;
    send_frame(8, 8'hC0, 1);
    wait_idle();
    check("post_reset_frame", frames_done - f0, 1);
    check("total_drop_cycles", drop_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
